// File: rtl/guvm_mem_pkg.sv
//==============================================================================
// Module      : guvm_mem_pkg
// Description : Shared types and constants for the multi-port OBI memory
//               responder (response word, LFSR stall-injection constants).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package guvm_mem_pkg;

    localparam int          WORD_BYTES = 4;
    localparam logic [15:0] LFSR_SEED  = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } mem_resp_t;

    // Galois right-shift form of x^16 + x^14 + x^13 + x^11 + 1
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        lfsr_next = cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/guvm_mem_port_pipe.sv
//==============================================================================
// Module      : guvm_mem_port_pipe
// Description : Per-port grant generation, outstanding counter and LATENCY-deep
//               response delay line. GUVM_MEM_STALL_INJECT_EN adds LFSR stalls.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module guvm_mem_port_pipe
    import guvm_mem_pkg::*;
#(
    parameter int LATENCY         = 1,
    parameter int MAX_OUTSTANDING = 2
`ifdef GUVM_MEM_STALL_INJECT_EN
    ,
    parameter logic [15:0] LFSR_INIT = LFSR_SEED
`endif
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      req_i,
    output logic      gnt_o,
    input  mem_resp_t resp_i,
    output logic      rvalid_o,
    output mem_resp_t resp_o
);

    localparam int               CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    logic [LATENCY-1:0]            valid_q, valid_d;
    mem_resp_t [LATENCY-1:0]       resp_q, resp_d;
    logic [CNT_W-1:0]              outstanding_q, outstanding_d;
    logic                          accept;
    logic                          stall;

`ifdef GUVM_MEM_STALL_INJECT_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q <= LFSR_INIT;
        end else begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign stall = (lfsr_q[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    assign gnt_o  = !rst_i && (outstanding_q < MAX_CNT) && !stall;
    assign accept = req_i && gnt_o;

    // Outputs are forced quiet while reset is held so no stale response leaks out
    assign rvalid_o = valid_q[LATENCY-1] & ~rst_i;
    assign resp_o   = rst_i ? '0 : resp_q[LATENCY-1];

    always_comb begin
        valid_d[0] = accept;
        resp_d[0]  = accept ? resp_i : '0;
        for (int s = 1; s < LATENCY; s++) begin
            valid_d[s] = valid_q[s-1];
            resp_d[s]  = resp_q[s-1];
        end
    end

    always_comb begin
        outstanding_d = outstanding_q;
        case ({accept, rvalid_o})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q       <= '0;
            resp_q        <= '0;
            outstanding_q <= '0;
        end else begin
            valid_q       <= valid_d;
            resp_q        <= resp_d;
            outstanding_q <= outstanding_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/guvm_obi_mem_responder.sv
//==============================================================================
// Module      : guvm_obi_mem_responder
// Description : NUM_PORTS-channel req/gnt/rvalid memory responder over one
//               shared word array with byte enables, range errors and a
//               backdoor preload port. GUVM_MEM_STALL_INJECT_EN enables stalls.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module guvm_obi_mem_responder
    import guvm_mem_pkg::*;
#(
    parameter int          NUM_PORTS       = 2,
    parameter int          DEPTH           = 1024,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int          LATENCY         = 1,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_PORTS-1:0]    req_i,
    output logic [NUM_PORTS-1:0]    gnt_o,
    input  logic [NUM_PORTS*32-1:0] addr_i,
    input  logic [NUM_PORTS-1:0]    we_i,
    input  logic [NUM_PORTS*4-1:0]  be_i,
    input  logic [NUM_PORTS*32-1:0] wdata_i,
    output logic [NUM_PORTS-1:0]    rvalid_o,
    output logic [NUM_PORTS*32-1:0] rdata_o,
    output logic [NUM_PORTS-1:0]    err_o,
    input  logic                    bd_we_i,
    input  logic [31:0]             bd_addr_i,
    input  logic [31:0]             bd_wdata_i
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [31:0]          mem_q [DEPTH];
    logic [NUM_PORTS-1:0] in_range;
    logic [NUM_PORTS-1:0] accept;
    logic [IDX_W-1:0]     idx [NUM_PORTS];

    logic [31:0]          bd_offset;
    logic                 bd_in_range;
    logic [IDX_W-1:0]     bd_idx;

    assign bd_offset   = bd_addr_i - BASE_ADDR;
    assign bd_in_range = ({1'b0, bd_offset} >> 2) < 33'(DEPTH);
    assign bd_idx      = bd_offset[IDX_W+1:2];

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic [31:0] offset;
        mem_resp_t   resp_in;
        mem_resp_t   resp_out;

        assign offset      = addr_i[p*32 +: 32] - BASE_ADDR;
        assign in_range[p] = ({1'b0, offset} >> 2) < 33'(DEPTH);
        assign idx[p]      = offset[IDX_W+1:2];
        assign accept[p]   = req_i[p] && gnt_o[p];

        // Read-before-write: the word is captured here, before this cycle's writes land
        always_comb begin
            resp_in = '0;
            if (!in_range[p]) begin
                resp_in.err = 1'b1;
            end else if (!we_i[p]) begin
                resp_in.rdata = mem_q[idx[p]];
            end
        end

        guvm_mem_port_pipe #(
            .LATENCY         (LATENCY),
            .MAX_OUTSTANDING (MAX_OUTSTANDING)
`ifdef GUVM_MEM_STALL_INJECT_EN
            ,
            .LFSR_INIT       (LFSR_SEED ^ 16'(p))
`endif
        ) u_pipe (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .req_i    (req_i[p]),
            .gnt_o    (gnt_o[p]),
            .resp_i   (resp_in),
            .rvalid_o (rvalid_o[p]),
            .resp_o   (resp_out)
        );

        assign rdata_o[p*32 +: 32] = resp_out.rdata;
        assign err_o[p]            = resp_out.err;
    end

    // Later non-blocking writes override earlier ones: backdoor first, then
    // ports from highest to lowest index so the lowest enabling port wins per byte.
    always_ff @(posedge clk_i) begin
        if (bd_we_i && bd_in_range) begin
            mem_q[bd_idx] <= bd_wdata_i;
        end
        for (int p = NUM_PORTS - 1; p >= 0; p--) begin
            if (accept[p] && we_i[p] && in_range[p]) begin
                for (int b = 0; b < WORD_BYTES; b++) begin
                    if (be_i[p*WORD_BYTES + b]) begin
                        mem_q[idx[p]][b*8 +: 8] <= wdata_i[p*32 + b*8 +: 8];
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_guvm_obi_mem_responder.sv
//==============================================================================
// Module      : tb_guvm_obi_mem_responder
// Description : Self-checking bench; two responders (LATENCY 1 and 4) share
//               stimulus and are compared against a queue-based memory model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_guvm_obi_mem_responder;

    localparam int NP    = 2;
    localparam int DEPTH = 1024;
    localparam int LAT_A = 1;
    localparam int MAX_A = 2;
    localparam int LAT_B = 4;
    localparam int MAX_B = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [NP-1:0]     req, we;
    logic [NP*32-1:0]  addr, wdata;
    logic [NP*4-1:0]   be;
    logic              bd_we;
    logic [31:0]       bd_addr, bd_wdata;

    logic [NP-1:0]     gnt_a, rvalid_a, err_a, gnt_b, rvalid_b, err_b;
    logic [NP*32-1:0]  rdata_a, rdata_b;

    int checks = 0;
    int errors = 0;

    guvm_obi_mem_responder #(
        .NUM_PORTS(NP), .DEPTH(DEPTH), .BASE_ADDR(32'h0),
        .LATENCY(LAT_A), .MAX_OUTSTANDING(MAX_A)
    ) u_dut_a (
        .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt_a), .addr_i(addr),
        .we_i(we), .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid_a),
        .rdata_o(rdata_a), .err_o(err_a), .bd_we_i(bd_we), .bd_addr_i(bd_addr),
        .bd_wdata_i(bd_wdata)
    );

    guvm_obi_mem_responder #(
        .NUM_PORTS(NP), .DEPTH(DEPTH), .BASE_ADDR(32'h0),
        .LATENCY(LAT_B), .MAX_OUTSTANDING(MAX_B)
    ) u_dut_b (
        .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt_b), .addr_i(addr),
        .we_i(we), .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid_b),
        .rdata_o(rdata_b), .err_o(err_b), .bd_we_i(bd_we), .bd_addr_i(bd_addr),
        .bd_wdata_i(bd_wdata)
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        int          due;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        mq [2*NP][$];
    logic [31:0] mmem [2][DEPTH];
    int          mcyc = 0;

    function automatic int lat_of(input int i);
        return (i == 0) ? LAT_A : LAT_B;
    endfunction

    function automatic int max_of(input int i);
        return (i == 0) ? MAX_A : MAX_B;
    endfunction

    function automatic bit in_rng(input logic [31:0] a);
        return (a >> 2) < 32'(DEPTH);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'(a >> 2);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic [NP-1:0] acc;
            acc = '0;
            for (int p = 0; p < NP; p++) begin
                int k;
                k = i*NP + p;
                if (rst) begin
                    mq[k].delete();
                end else begin
                    bit g;
                    g = mq[k].size() < max_of(i);
                    if (mq[k].size() > 0 && mq[k][0].due == mcyc) void'(mq[k].pop_front());
                    if (req[p] && g) begin
                        exp_t        e;
                        logic [31:0] a;
                        a       = addr[p*32 +: 32];
                        acc[p]  = 1'b1;
                        e.due   = mcyc + lat_of(i);
                        e.err   = !in_rng(a);
                        e.rdata = (we[p] || e.err) ? 32'h0 : mmem[i][widx(a)];
                        mq[k].push_back(e);
                    end
                end
            end
            if (bd_we && in_rng(bd_addr)) mmem[i][widx(bd_addr)] = bd_wdata;
            for (int p = 0; p < NP; p++) begin
                logic [31:0] ap;
                ap = addr[p*32 +: 32];
                if (acc[p] && we[p] && in_rng(ap)) begin
                    for (int b = 0; b < 4; b++) begin
                        bit blocked;
                        blocked = 1'b0;
                        for (int q = 0; q < p; q++) begin
                            logic [31:0] aq;
                            aq = addr[q*32 +: 32];
                            if (acc[q] && we[q] && in_rng(aq) && widx(aq) == widx(ap) && be[q*4+b])
                                blocked = 1'b1;
                        end
                        if (be[p*4+b] && !blocked)
                            mmem[i][widx(ap)][b*8 +: 8] = wdata[p*32 + b*8 +: 8];
                    end
                end
            end
        end
        mcyc++;
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic [NP-1:0]    ag, av, ae;
            logic [NP*32-1:0] ad;
            ag = (i == 0) ? gnt_a    : gnt_b;
            av = (i == 0) ? rvalid_a : rvalid_b;
            ae = (i == 0) ? err_a    : err_b;
            ad = (i == 0) ? rdata_a  : rdata_b;
            for (int p = 0; p < NP; p++) begin
                int k;
                bit ge, ve;
                k  = i*NP + p;
                ge = !rst && (mq[k].size() < max_of(i));
                ve = !rst && (mq[k].size() > 0) && (mq[k][0].due == mcyc);
                chk($sformatf("m%0d gnt[%0d]", i, p), 32'(ag[p]), 32'(ge));
                chk($sformatf("m%0d rvalid[%0d]", i, p), 32'(av[p]), 32'(ve));
                if (ve) begin
                    chk($sformatf("m%0d rdata[%0d]", i, p), ad[p*32 +: 32], mq[k][0].rdata);
                    chk($sformatf("m%0d err[%0d]", i, p), 32'(ae[p]), 32'(mq[k][0].err));
                end else if (rst) begin
                    chk($sformatf("m%0d rst rdata[%0d]", i, p), ad[p*32 +: 32], 32'h0);
                    chk($sformatf("m%0d rst err[%0d]", i, p), 32'(ae[p]), 32'h0);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        req = '0; we = '0; be = '0; addr = '0; wdata = '0;
        bd_we = 1'b0; bd_addr = '0; bd_wdata = '0;
    endtask

    task automatic next();
        @(posedge clk);
        #2;
        idle();
    endtask

    task automatic settle(input int n);
        repeat (n) next();
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 15);
        if (r == 0) return 32'h0000_1000 | 32'($urandom_range(0, 4095));
        if (r == 1) return 32'hFFFF_FFFC;
        return (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
    endfunction

    initial begin
        logic [5:0] gnt_pat;
        rst = 1'b1;
        idle();
        @(negedge clk);
        chk("reset gnt_a", 32'(gnt_a), 32'h0);
        chk("reset rvalid_b", 32'(rvalid_b), 32'h0);
        chk("reset rdata_a", rdata_a[31:0], 32'h0);
        next(); next();
        rst = 1'b0;

        for (int w = 0; w < 16; w++) begin
            next();
            bd_we = 1'b1; bd_addr = 32'(w) << 2; bd_wdata = {16'hC0DE, 16'(w)};
        end
        settle(2);

        // backdoor preload then read through port 1
        next(); bd_we = 1'b1; bd_addr = 32'h14; bd_wdata = 32'hDEAD_BEEF;
        next(); req[1] = 1'b1; addr[63:32] = 32'h14;
        @(negedge clk); chk("t1 gnt", 32'(gnt_a[1]), 32'h1);
        next();
        @(negedge clk);
        chk("t1 rvalid", 32'(rvalid_a[1]), 32'h1);
        chk("t1 rdata", rdata_a[63:32], 32'hDEAD_BEEF);
        chk("t1 err", 32'(err_a[1]), 32'h0);
        settle(6);

        // byte-enabled write then read
        next(); req[1] = 1'b1; we[1] = 1'b1; addr[63:32] = 32'h14;
                wdata[63:32] = 32'h1122_3344; be[7:4] = 4'b0101;
        next(); req[1] = 1'b1; addr[63:32] = 32'h14;
        @(negedge clk);
        chk("t2 wr rvalid", 32'(rvalid_a[1]), 32'h1);
        chk("t2 wr rdata", rdata_a[63:32], 32'h0);
        next();
        @(negedge clk); chk("t2 rd rdata", rdata_a[63:32], 32'hDE22_BE44);
        settle(6);

        // out-of-range write and read; word 0 must not be touched
        next(); req[0] = 1'b1; we[0] = 1'b1; addr[31:0] = 32'h1000;
                wdata[31:0] = 32'hFFFF_FFFF; be[3:0] = 4'hF;
        next(); req[0] = 1'b1; addr[31:0] = 32'h1000;
        @(negedge clk); chk("t4 wr err", 32'(err_a[0]), 32'h1);
        next(); req[0] = 1'b1; addr[31:0] = 32'h0;
        @(negedge clk);
        chk("t4 rd err", 32'(err_a[0]), 32'h1);
        chk("t4 rd rdata", rdata_a[31:0], 32'h0);
        next();
        @(negedge clk); chk("t4 word0", rdata_a[31:0], 32'hC0DE_0000);
        settle(6);

        // same-word writes from both ports, lowest port wins per byte
        next(); req = 2'b11; we = 2'b11; addr = {32'hC, 32'hC};
                be = {4'b1111, 4'b0011}; wdata = {32'h5555_5555, 32'hAAAA_AAAA};
        @(negedge clk); chk("t5 gnt", 32'(gnt_a), 32'h3);
        next(); req[0] = 1'b1; addr[31:0] = 32'hC;
        next();
        @(negedge clk); chk("t5 rdata", rdata_a[31:0], 32'h5555_AAAA);
        settle(8);

        // LATENCY 4 / MAX 2 with req held: grant throttling and in-order data
        gnt_pat = 6'b100011;
        for (int k = 0; k < 6; k++) begin
            next(); req[0] = 1'b1; addr[31:0] = 32'(k + 1) << 2;
            @(negedge clk);
            chk($sformatf("t3 gnt%0d", k), 32'(gnt_b[0]), 32'(gnt_pat[k]));
            if (k == 4) chk("t3 rdata0", rdata_b[31:0], 32'hC0DE_0001);
            if (k == 5) chk("t3 rdata1", rdata_b[31:0], 32'hC0DE_0002);
        end
        settle(8);

        // reset one cycle after an accept discards the in-flight response
        next(); req[0] = 1'b1; addr[31:0] = 32'h8;
        next(); rst = 1'b1;
        @(negedge clk);
        chk("t6 gnt_b in rst", 32'(gnt_b), 32'h0);
        chk("t6 gnt_a in rst", 32'(gnt_a), 32'h0);
        next(); rst = 1'b0;
        @(negedge clk); chk("t6 gnt after rst", 32'(gnt_b[0]), 32'h1);
        for (int k = 0; k < 6; k++) begin
            next();
            @(negedge clk); chk("t6 no rvalid", 32'(rvalid_b[0]), 32'h0);
        end

        // randomized traffic, occasional resets
        for (int n = 0; n < 3000; n++) begin
            next();
            rst = ($urandom_range(0, 299) == 0);
            for (int p = 0; p < NP; p++) begin
                req[p]             = ($urandom_range(0, 3) != 0);
                we[p]              = 1'($urandom_range(0, 1));
                be[p*4 +: 4]       = 4'($urandom_range(0, 15));
                wdata[p*32 +: 32]  = $urandom;
                addr[p*32 +: 32]   = rand_addr();
            end
            bd_we    = !rst && ($urandom_range(0, 15) == 0);
            bd_addr  = rand_addr();
            bd_wdata = $urandom;
        end
        next();
        rst = 1'b0;
        settle(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
